// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble 1,1,0, eight data bits MSB first, optional
// even-parity bit (macro SEQ_FRAME_PARITY_EN), then GAP forced-0 idle cycles.
module seq_frame_tx #(
    parameter int unsigned GAP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       z,
    output logic       frame_active,
    output logic       done,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
`ifdef SEQ_FRAME_PARITY_EN
        S_PAR,
`endif
        S_GAP
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] sh, sh_n;
    logic       z_n, active_n, last_bit;
`ifdef SEQ_FRAME_PARITY_EN
    logic       par, par_n;
`endif

    assign in_ready = (state == S_IDLE);

    // NOTE: every variable gets its default before the case so no path can infer a latch.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sh_n     = sh;
        last_bit = 1'b0;
`ifdef SEQ_FRAME_PARITY_EN
        par_n    = par;
`endif
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_n = S_PRE;
                    cnt_n   = 4'd0;
                    sh_n    = in_data;
`ifdef SEQ_FRAME_PARITY_EN
                    par_n   = ^in_data;
`endif
                end
            end
            S_PRE: begin
                if (cnt == 4'd2) begin
                    state_n = S_DATA;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            S_DATA: begin
                if (cnt == 4'd7) begin
`ifdef SEQ_FRAME_PARITY_EN
                    state_n = S_PAR;
                    cnt_n   = 4'd0;
`else
                    last_bit = 1'b1;
`endif
                end else begin
                    cnt_n = cnt + 4'd1;
                    sh_n  = {sh[6:0], 1'b0};
                end
            end
`ifdef SEQ_FRAME_PARITY_EN
            S_PAR: last_bit = 1'b1;
`endif
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (last_bit) begin
            state_n = (GAP == 0) ? S_IDLE : S_GAP;
            cnt_n   = 4'd0;
        end

        // z is registered, so it is derived from the state being entered.
        z_n      = 1'b0;
        active_n = 1'b0;
        case (state_n)
            S_PRE: begin
                z_n      = (cnt_n != 4'd2);
                active_n = 1'b1;
            end
            S_DATA: begin
                z_n      = sh_n[7];
                active_n = 1'b1;
            end
`ifdef SEQ_FRAME_PARITY_EN
            S_PAR: begin
                z_n      = par_n;
                active_n = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            sh           <= 8'd0;
            z            <= 1'b0;
            frame_active <= 1'b0;
            done         <= 1'b0;
            frame_cnt    <= 8'd0;
`ifdef SEQ_FRAME_PARITY_EN
            par          <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            sh           <= sh_n;
            z            <= z_n;
            frame_active <= active_n;
            done         <= last_bit;
            if (last_bit) frame_cnt <= frame_cnt + 8'd1;
`ifdef SEQ_FRAME_PARITY_EN
            par          <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: three instances with GAP = 0, 1, 3 and a
// scoreboard queue of expected z bits filled when each payload is offered.
module tb_seq_frame_tx;

`ifdef SEQ_FRAME_PARITY_EN
    localparam int FLEN = 12;
`else
    localparam int FLEN = 11;
`endif

    logic       clk = 1'b0;
    logic       reset    [3];
    logic [7:0] in_data  [3];
    logic       in_valid [3];
    logic       in_ready [3];
    logic       z        [3];
    logic       fa       [3];
    logic       done     [3];
    logic [7:0] fcnt     [3];

    logic [7:0] fc_model [3];
    bit         sbq[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        seq_frame_tx #(.GAP(g == 2 ? 3 : g)) u_dut (
            .clk         (clk),
            .reset       (reset[g]),
            .in_data     (in_data[g]),
            .in_valid    (in_valid[g]),
            .in_ready    (in_ready[g]),
            .z           (z[g]),
            .frame_active(fa[g]),
            .done        (done[g]),
            .frame_cnt   (fcnt[g])
        );
    end

    function automatic int gap_of(input int d);
        return (d == 2) ? 3 : d;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Called at a negedge with the instance idle; returns at the negedge where it is idle again.
    task automatic send_frame(input int d, input logic [7:0] data, input bit hold, input bit poke);
        bit exp_bit;
        sbq.push_back(1'b1);
        sbq.push_back(1'b1);
        sbq.push_back(1'b0);
        for (int i = 7; i >= 0; i--) sbq.push_back(data[i]);
`ifdef SEQ_FRAME_PARITY_EN
        sbq.push_back(^data);
`endif
        chk1("ready_before", in_ready[d], 1'b1);
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        for (int i = 0; i < FLEN; i++) begin
            @(negedge clk);
            if (i == 0) begin
                in_valid[d] = hold;
                in_data[d]  = ~data;
            end
            if (poke && i == 5) in_valid[d] = 1'b1;
            if (poke && i == 7) in_valid[d] = hold;
            exp_bit = sbq.pop_front();
            chk1("z_bit", z[d], exp_bit);
            chk1("active_bit", fa[d], 1'b1);
            chk1("ready_busy", in_ready[d], 1'b0);
            chk1("done_early", done[d], 1'b0);
        end
        @(negedge clk);
        fc_model[d] = fc_model[d] + 8'd1;
        chk1("done_pulse", done[d], 1'b1);
        chk1("active_end", fa[d], 1'b0);
        chk8("frame_cnt", fcnt[d], fc_model[d]);
        for (int k = 0; k < gap_of(d); k++) begin
            chk1("gap_z", z[d], 1'b0);
            chk1("gap_ready", in_ready[d], 1'b0);
            chk1("gap_active", fa[d], 1'b0);
            chk1("gap_done", done[d], k == 0);
            @(negedge clk);
        end
        chk1("idle_ready", in_ready[d], 1'b1);
        chk1("idle_z", z[d], 1'b0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            reset[d]    = 1'b1;
            in_valid[d] = 1'b1;
            in_data[d]  = 8'hFF;
            fc_model[d] = 8'd0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk1("rst_z", z[d], 1'b0);
            chk1("rst_active", fa[d], 1'b0);
            chk1("rst_done", done[d], 1'b0);
            chk8("rst_cnt", fcnt[d], 8'd0);
            chk1("rst_ready", in_ready[d], 1'b1);
            reset[d]    = 1'b0;
            in_valid[d] = 1'b0;
        end
        @(negedge clk);

        // Basic frames on GAP=1 instance
        send_frame(1, 8'hA5, 1'b0, 1'b0);
        send_frame(1, 8'h07, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset during the third data bit, with in_valid high on the reset edge
        sbq.delete();
        in_valid[1] = 1'b1;
        in_data[1]  = 8'h3C;
        @(negedge clk);
        in_valid[1] = 1'b0;
        repeat (5) @(negedge clk);
        chk1("mid_active", fa[1], 1'b1);
        reset[1]    = 1'b1;
        in_valid[1] = 1'b1;
        @(negedge clk);
        reset[1]    = 1'b0;
        in_valid[1] = 1'b0;
        fc_model[1] = 8'd0;
        chk1("abort_z", z[1], 1'b0);
        chk1("abort_active", fa[1], 1'b0);
        chk1("abort_ready", in_ready[1], 1'b1);
        chk8("abort_cnt", fcnt[1], 8'd0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk1("abort_no_done", done[1], 1'b0);
            chk1("abort_idle", in_ready[1], 1'b1);
        end

        // GAP=0, in_valid held: back-to-back frames
        for (int i = 0; i < 3; i++) send_frame(0, 8'hFF, 1'b1, 1'b0);
        in_valid[0] = 1'b0;
        chk8("b2b_cnt", fcnt[0], 8'd3);
        @(negedge clk);

        // GAP=3 with in_valid pulsed during DATA
        send_frame(2, 8'h5A, 1'b0, 1'b1);
        send_frame(2, 8'h81, 1'b0, 1'b0);

        // Frame counter wrap on GAP=0 instance
        reset[0] = 1'b1;
        @(negedge clk);
        reset[0]    = 1'b0;
        fc_model[0] = 8'd0;
        for (int i = 0; i < 256; i++) send_frame(0, 8'(i * 37 + 11), 1'b1, 1'b0);
        in_valid[0] = 1'b0;
        chk8("wrap_cnt", fcnt[0], 8'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_frame_tx.md
SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 SHALL have parameter GAP, default 1: number of forced-0 idle bit cycles after each frame, legal range 0..15.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_data  input  8  payload byte to transmit.
REQ-005 SHALL have port in_valid  input  1  payload offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a payload.
REQ-007 SHALL have port z  output  1  registered serial bit stream.
REQ-008 SHALL have port frame_active  output  1  high while a preamble, data or parity bit is on z.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking frame completion.
REQ-010 SHALL have port frame_cnt  output  8  count of completed frames.

Function
REQ-011 SHALL implement states IDLE, PRE, DATA, PAR, GAP with a 4-bit bit/gap counter.
REQ-012 SHALL drive in_ready = 1 only while state is IDLE; in_ready SHALL be 0 in every other state.
REQ-013 SHALL accept a payload on a rising edge where in_valid=1 and in_ready=1, latching in_data into an internal shift register; later in_data changes SHALL be ignored.
REQ-014 SHALL present preamble bits 1,1,0 on z in the 3 cycles after acceptance (state PRE); first preamble bit visible in the cycle after the accepting edge.
REQ-015 SHALL then present the 8 latched data bits MSB first, one per cycle (state DATA).
REQ-016 SHALL present, in PAR, one even-parity bit equal to XOR of the 8 latched bits (only when compiled in, see REQ-027).
REQ-017 SHALL hold frame_active=1 exactly during PRE, DATA and PAR cycles, else 0.
REQ-018 SHALL hold z=0 in IDLE and GAP.
REQ-019 SHALL, after the last frame bit, enter GAP for GAP cycles, then IDLE; with GAP=0, SHALL go directly to IDLE.
REQ-020 SHALL assert done for exactly the one cycle following the last frame bit, and increment frame_cnt on that same edge; frame_cnt SHALL wrap 255 -> 0.
REQ-021 SHALL, with GAP=0 and in_valid held high, give back-to-back frames separated by exactly one z=0 IDLE cycle.
REQ-022 SHALL ignore in_valid in all non-IDLE states; a held in_valid SHALL be accepted at the next IDLE cycle only.
REQ-023 Frame length on z: 11 cycles without parity, 12 with parity; latency acceptance-edge to done = frame length + 1 cycles.

Reset
REQ-024 SHALL, on any rising edge with reset=1, force state IDLE, z=0, frame_active=0, done=0, frame_cnt=0, counter=0, shift register=0.
REQ-025 SHALL, on reset mid-frame, abandon the frame without done pulse or frame_cnt increment; in_ready=1 from the cycle after the reset edge.
REQ-026 SHALL take no acceptance on an edge where reset=1, regardless of in_valid.

Configuration
REQ-027 SHALL compile the PAR state and parity bit only when macro SEQ_FRAME_PARITY_EN is defined; frame = 12 bits.
REQ-028 SHALL, without SEQ_FRAME_PARITY_EN, go DATA -> GAP/IDLE directly; frame = 11 bits; port list unchanged.

Verification
REQ-029 in_data=8'hA5, PARITY_EN on, GAP=1 -> z = 1,1,0,1,0,1,0,0,1,0,1,0 then one 0 gap cycle; done pulses once; frame_cnt 0 -> 1.
REQ-030 in_data=8'h07, PARITY_EN on -> data bits 0,0,0,0,0,1,1,1, parity bit 1; PARITY_EN off -> 11-bit frame, no parity bit, done one cycle earlier.
REQ-031 reset asserted during 3rd data bit -> next cycle z=0, frame_active=0, in_ready=1, done never pulses, frame_cnt=0.
REQ-032 GAP=0, in_valid held high, in_data=8'hFF for 3 frames -> each frame followed by exactly one z=0 cycle; frame_cnt=3.
REQ-033 GAP=3, in_valid pulsed during DATA -> not accepted; in_ready stays 0 for frame + 3 gap cycles; z=0 for 3 gap cycles.
REQ-034 256 back-to-back frames -> frame_cnt wraps to 0 on the 256th done pulse.
